// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   DATA_W       : data/address width, taken from the `DATA_WIDTH macro
//   arb_state_t  : arbiter FSM state encoding
//   PORT_CORE    : port index of the core memory stage (port 0)
//   PORT_DBG     : port index of the debug/DMA master (port 1)
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package dmem_arb_pkg;

   localparam int DATA_W = `DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Command/response bus between the arbiter and the data memory.
//   mem_req_o    : command valid (arbiter -> memory)
//   mem_we_o     : 1 = store, 0 = load
//   mem_addr_o   : byte address
//   mem_wdata_o  : store data
//   mem_funct3_o : access size/sign code
//   mem_ack_i    : single-cycle completion pulse (memory -> arbiter)
//   mem_rdata_i  : load data, valid with mem_ack_i
// master = arbiter side, slave = memory side.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
   import dmem_arb_pkg::*;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [DATA_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [2:0]        mem_funct3_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o,
      output mem_ack_i, mem_rdata_i
   );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin winner selection, purely combinational.
//   req        : request vector, bit N = port N
//   last_owner : port index that received the previous grant
//   gnt        : one-hot winner (or 0 when nobody requests)
// A lone requester always wins; on a tie the port that did not own the
// previous grant wins.
// ---------------------------------------------------------------------------
module rr_arbiter2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_owner == PORT_DBG) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one data-memory port between the core memory stage (port 0) and a
// debug/DMA master (port 1). One transaction outstanding at a time; a stuck
// memory is aborted after TIMEOUT_CYCLES busy cycles with an error flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pN_req_i/we_i/...   : request and command from port N
//   pN_gnt_o            : request accepted this cycle (combinational pulse)
//   pN_done_o/err_o     : completion pulse and timeout flag for port N
//   rdata_o             : load data, non-zero only during a done pulse
//   core_stall_o        : port 0 has a request that has not completed yet
//   mem                 : command/response bus to the data memory
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req_i,
   input  logic              p0_we_i,
   input  logic [DATA_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_wdata_i,
   input  logic [2:0]        p0_funct3_i,
   output logic              p0_gnt_o,
   output logic              p0_done_o,
   output logic              p0_err_o,
   input  logic              p1_req_i,
   input  logic              p1_we_i,
   input  logic [DATA_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_wdata_i,
   input  logic [2:0]        p1_funct3_i,
   output logic              p1_gnt_o,
   output logic              p1_done_o,
   output logic              p1_err_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              core_stall_o,
   dmem_arbiter_if.master    mem
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t        state, state_nxt;
   logic [1:0]        arb_gnt;
   logic              grant_any;
   logic              last_owner;
   logic              owner;
   logic [CNT_W-1:0]  cnt;
   logic              cmd_we;
   logic [DATA_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [2:0]        cmd_funct3;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   rr_arbiter2 u_rr_arbiter2 (
      .req        ({p1_req_i, p0_req_i}),
      .last_owner (last_owner),
      .gnt        (arb_gnt)
   );

   assign grant_any = (state == ST_IDLE) && (arb_gnt != 2'b00);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; an ack in the last timeout cycle still exits normally
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (grant_any) state_nxt = ST_BUSY;
         ST_BUSY: if (mem.mem_ack_i || (cnt == CNT_LAST)) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command latch, ownership, timeout counter and response capture.
   // last_owner resets to port 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= PORT_DBG;
         owner      <= PORT_CORE;
         cnt        <= '0;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_funct3 <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  owner      <= arb_gnt[1];
                  last_owner <= arb_gnt[1];
                  cnt        <= '0;
                  cmd_we     <= arb_gnt[1] ? p1_we_i     : p0_we_i;
                  cmd_addr   <= arb_gnt[1] ? p1_addr_i   : p0_addr_i;
                  cmd_wdata  <= arb_gnt[1] ? p1_wdata_i  : p0_wdata_i;
                  cmd_funct3 <= arb_gnt[1] ? p1_funct3_i : p0_funct3_i;
               end
            end
            ST_BUSY: begin
               if (cnt != '1) cnt <= cnt + 1'b1;
               if (mem.mem_ack_i) begin
                  rdata_q <= cmd_we ? '0 : mem.mem_rdata_i;
                  err_q   <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            ST_RESP: cnt <= '0;
            default: cnt <= '0;
         endcase
      end
   end

   assign mem.mem_we_o     = cmd_we;
   assign mem.mem_addr_o   = cmd_addr;
   assign mem.mem_wdata_o  = cmd_wdata;
   assign mem.mem_funct3_o = cmd_funct3;

   // Output logic; grants and stall are gated by rst_n so every output is
   // quiet while reset is asserted, even with requests pending.
   always_comb begin
      p0_gnt_o      = 1'b0;
      p1_gnt_o      = 1'b0;
      p0_done_o     = 1'b0;
      p1_done_o     = 1'b0;
      p0_err_o      = 1'b0;
      p1_err_o      = 1'b0;
      rdata_o       = '0;
      mem.mem_req_o = 1'b0;
      case (state)
         ST_IDLE: begin
            p0_gnt_o = rst_n & arb_gnt[0];
            p1_gnt_o = rst_n & arb_gnt[1];
         end
         ST_BUSY: mem.mem_req_o = 1'b1;
         ST_RESP: begin
            p0_done_o = (owner == PORT_CORE);
            p1_done_o = (owner == PORT_DBG);
            p0_err_o  = (owner == PORT_CORE) & err_q;
            p1_err_o  = (owner == PORT_DBG)  & err_q;
            rdata_o   = rdata_q;
         end
         default: ;
      endcase
      core_stall_o = rst_n & p0_req_i & ~p0_done_o;
   end

endmodule
